// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, address regions,
// MMIO register offsets, the latched request bundle and a byte-lane mask helper.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RG_RAM  = 2'd0,
        RG_MMIO = 2'd1,
        RG_NONE = 2'd2
    } region_t;

    // Word offsets inside the MMIO window (addr[3:2]).
    localparam logic [1:0] MMIO_LED = 2'd0;
    localparam logic [1:0] MMIO_CYC = 2'd1;
    localparam logic [1:0] MMIO_ACC = 2'd2;
    localparam logic [1:0] MMIO_RSV = 2'd3;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dreq_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One 8-bit synchronous RAM lane with registered read data.
// Ports: clk, en (access enable), we (write), addr (word index), din, dout.
module dmem_bank #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);

    logic [7:0] mem [2**AW];
    logic [7:0] dout_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout_q <= mem[addr];
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake onto a 4-lane byte RAM and an MMIO
// block (LED reg, cycle counter, access counter). Ports: clk, rst (async, high),
// req/wen/addr/be/wdata from the core; rdata/ack/err back; led_data to display.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] led_data
);

    localparam int WA_W = ADDR_W - 2;

    state_t      state_q, state_d;
    dreq_t       req_q, req_d;
    region_t     region_q, region_d;
    region_t     region_in;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] led_q, led_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] acc_q, acc_d;

    logic            acc_err;
    logic            bank_rd;
    logic            bank_wr;
    logic [WA_W-1:0] bank_addr;
    logic [3:0]      bank_en;
    logic [3:0]      bank_we;
    logic [31:0]     bank_dout;
    logic            unused_bits;

    assign unused_bits = ^{addr[1:0], req_q.addr[31:ADDR_W], req_q.addr[1:0]};

    always_comb begin
        region_in = RG_NONE;
        if (addr[31:ADDR_W] == '0) begin
            region_in = RG_RAM;
        end else if (addr[31:4] == MMIO_BASE[31:4]) begin
            region_in = RG_MMIO;
        end
    end

    assign acc_err = (region_q == RG_NONE) || (req_q.be == 4'b0000) ||
                     ((region_q == RG_MMIO) && (req_q.addr[3:2] == MMIO_RSV));

    // RAM read is launched while the request is accepted, so the lane data is
    // ready in ACCESS and can be masked into the rdata register there.
    assign bank_rd   = (state_q == ST_IDLE) && req && !wen &&
                       (region_in == RG_RAM);
    assign bank_wr   = (state_q == ST_ACCESS) && req_q.wen &&
                       (region_q == RG_RAM) && !acc_err;
    assign bank_addr = (state_q == ST_IDLE) ? addr[ADDR_W-1:2]
                                            : req_q.addr[ADDR_W-1:2];
    assign bank_we   = {4{bank_wr}} & req_q.be;
    assign bank_en   = {4{bank_rd}} | bank_we;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        dmem_bank #(.AW(WA_W)) u_bank (
            .clk  (clk),
            .en   (bank_en[i]),
            .we   (bank_we[i]),
            .addr (bank_addr),
            .din  (req_q.wdata[8*i+7:8*i]),
            .dout (bank_dout[8*i+7:8*i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_d    = req_q;
        region_d = region_q;
        rdata_d  = '0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        led_d    = led_q;
        cyc_d    = cyc_q + 32'd1;
        acc_d    = acc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    req_d    = '{wen: wen, addr: addr, be: be, wdata: wdata};
                    region_d = region_in;
                end
            end
            ST_ACCESS: begin
                ack_d = 1'b1;
                err_d = acc_err;
                if (!acc_err && region_q == RG_RAM && !req_q.wen) begin
                    rdata_d = bank_dout & lane_mask(req_q.be);
                end
                if (!acc_err && region_q == RG_MMIO) begin
                    unique case (req_q.addr[3:2])
                        MMIO_LED: begin
                            if (req_q.wen) begin
                                if (req_q.be[0]) led_d[7:0]  = req_q.wdata[7:0];
                                if (req_q.be[1]) led_d[15:8] = req_q.wdata[15:8];
                            end else begin
                                rdata_d = {16'h0, led_q};
                            end
                        end
                        MMIO_CYC: if (!req_q.wen) rdata_d = cyc_q;
                        MMIO_ACC: if (!req_q.wen) rdata_d = acc_q;
                        default:  rdata_d = '0;
                    endcase
                end
            end
            ST_RESP: begin
                acc_d = acc_q + 32'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= '0;
            region_q <= RG_NONE;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            led_q    <= '0;
            cyc_q    <= '0;
            acc_q    <= '0;
        end else begin
            req_q    <= req_d;
            region_q <= region_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            led_q    <= led_d;
            cyc_q    <= cyc_d;
            acc_q    <= acc_d;
        end
    end

    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign led_data = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// accesses checked against a word-level reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic [15:0] led_data;

    int total = 0;
    int bad = 0;
    int unsigned tbcyc;

    logic [31:0] mem_m [64];
    logic [15:0] led_m;
    int unsigned acc_m;

    dmem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wen      (wen),
        .addr     (addr),
        .be       (be),
        .wdata    (wdata),
        .rdata    (rdata),
        .ack      (ack),
        .err      (err),
        .led_data (led_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tbcyc <= 0;
        else     tbcyc <= tbcyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] emask(input logic [3:0] b);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
        return m;
    endfunction

    // Reference model: applies one access, returns expected rdata/err.
    task automatic model(input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] cyc_access,
                         output logic [31:0] er, output logic ee);
        bit is_ram, is_mmio;
        int unsigned idx;
        is_ram  = (a < 32'h100);
        is_mmio = (a >= 32'hFFFF_0000) && (a <= 32'hFFFF_000F);
        idx     = (a % 256) / 4;
        ee = !(is_ram || is_mmio) || b == 4'h0 ||
             (is_mmio && ((a % 16) / 4) == 3);
        er = '0;
        if (!ee && is_ram) begin
            if (w) mem_m[idx] = (mem_m[idx] & ~emask(b)) | (d & emask(b));
            else   er = mem_m[idx] & emask(b);
        end
        if (!ee && is_mmio) begin
            case ((a % 16) / 4)
                0: begin
                    if (w) begin
                        if (b[0]) led_m[7:0]  = d[7:0];
                        if (b[1]) led_m[15:8] = d[15:8];
                    end else begin
                        er = {16'h0, led_m};
                    end
                end
                1: if (!w) er = cyc_access;
                2: if (!w) er = acc_m;
                default: er = '0;
            endcase
        end
        acc_m++;
    endtask

    task automatic run(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic e, output int lat, output int unsigned cyc_at);
        @(posedge clk);
        #1;
        req = 1'b1; wen = w; addr = a; be = b; wdata = d;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                lat = i;
                break;
            end
        end
        rd = rdata; e = err; cyc_at = tbcyc;
        req = 1'b0;
    endtask

    task automatic step(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        logic [31:0] rd, er;
        logic e, ee;
        int lat;
        int unsigned ca;
        run(w, a, b, d, rd, e, lat, ca);
        model(w, a, b, d, ca - 1, er, ee);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_rdata"}, rd, er);
        chk({tag, "_err"}, {31'h0, e}, {31'h0, ee});
        chk({tag, "_led"}, {16'h0, led_data}, {16'h0, led_m});
    endtask

    initial begin
        logic [31:0] ra, rd2;
        int c;
        int nack;
        int ack_cyc [3];

        led_m = '0;
        acc_m = 0;
        #12;
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_led", {16'h0, led_data}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            logic [31:0] rd;
            logic e, ee;
            logic [31:0] er;
            int lat;
            int unsigned ca;
            logic [31:0] v;
            v = $urandom;
            run(1'b1, i * 4, 4'hF, v, rd, e, lat, ca);
            model(1'b1, i * 4, 4'hF, v, ca - 1, er, ee);
        end

        step("word_wr", 1'b1, 32'h20, 4'hF, 32'hDEADBEEF);
        step("word_rd", 1'b0, 32'h20, 4'hF, 32'h0);
        chk("word_val", mem_m[8], 32'hDEADBEEF);

        step("lane_wr1", 1'b1, 32'h24, 4'hF, 32'h11223344);
        step("lane_wr2", 1'b1, 32'h24, 4'b0101, 32'hAABBCCDD);
        step("lane_rdf", 1'b0, 32'h24, 4'hF, 32'h0);
        chk("lane_val", mem_m[9], 32'h11BB33DD);
        step("lane_rd2", 1'b0, 32'h24, 4'b0010, 32'h0);

        step("led_wr", 1'b1, 32'hFFFF_0000, 4'hF, 32'h1234_5678);
        chk("led_val", {16'h0, led_data}, 32'h0000_5678);
        step("led_hi", 1'b1, 32'hFFFF_0000, 4'b1110, 32'h0000_9A00);
        step("led_rd", 1'b0, 32'hFFFF_0000, 4'hF, 32'h0);
        step("cyc_wr", 1'b1, 32'hFFFF_0004, 4'hF, 32'h0);
        step("cyc_rd", 1'b0, 32'hFFFF_0004, 4'hF, 32'h0);
        step("acc_rd", 1'b0, 32'hFFFF_0008, 4'hF, 32'h0);
        step("rsv_rd", 1'b0, 32'hFFFF_000C, 4'hF, 32'h0);

        step("unm_rd", 1'b0, 32'h0001_0000, 4'hF, 32'h0);
        step("be0_wr", 1'b1, 32'h20, 4'h0, 32'h0BAD_0BAD);
        step("be0_chk", 1'b0, 32'h20, 4'hF, 32'h0);

        // Back-to-back: req held across three reads.
        @(posedge clk);
        #1;
        req = 1'b1; wen = 1'b0; be = 4'hF; addr = 32'h20;
        c = 0;
        nack = 0;
        for (int i = 0; i < 12 && nack < 3; i++) begin
            @(posedge clk);
            #1;
            c++;
            if (ack) begin
                ra = 32'h20 + 32'(nack * 4);
                model(1'b0, ra, 4'hF, 32'h0, 32'h0, rd2, ack_cyc[0][0]);
                chk("b2b_rdata", rdata, rd2);
                chk("b2b_err", {31'h0, err}, 32'h0);
                ack_cyc[nack] = c;
                nack++;
                addr = 32'h20 + 32'(nack * 4);
                if (nack == 3) req = 1'b0;
            end
        end
        req = 1'b0;
        chk("b2b_n", nack, 3);
        chk("b2b_c0", ack_cyc[0], 2);
        chk("b2b_c1", ack_cyc[1], 5);
        chk("b2b_c2", ack_cyc[2], 8);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic [3:0] b;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = 32'($urandom_range(0, 255));
            else if (sel < 9) a = 32'hFFFF_0000 + 32'($urandom_range(0, 15));
            else              a = 32'h0000_0100 + 32'($urandom_range(0, 32'hFFFF));
            b = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            step("rand", 1'($urandom), a, b, $urandom);
        end

        // Reset during ACCESS of a write to 0x10 must abort it.
        @(posedge clk);
        #1;
        req = 1'b1; wen = 1'b1; addr = 32'h10; be = 4'hF; wdata = ~mem_m[4];
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        req = 1'b0;
        chk("abort_ack0", {31'h0, ack}, 32'h0);
        chk("abort_led", {16'h0, led_data}, 32'h0);
        @(posedge clk);
        #1;
        chk("abort_ack1", {31'h0, ack}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        rst = 1'b0;
        led_m = '0;
        acc_m = 0;

        step("post_rd10", 1'b0, 32'h10, 4'hF, 32'h0);
        step("post_cyc", 1'b0, 32'hFFFF_0004, 4'hF, 32'h0);
        step("post_ledw", 1'b1, 32'hFFFF_0000, 4'h3, 32'h0000_BEEF);
        step("post_cycw", 1'b1, 32'hFFFF_0004, 4'hF, 32'h1);
        step("post_ledr", 1'b0, 32'hFFFF_0000, 4'hF, 32'h0);
        chk("acc_model5", acc_m, 5);
        step("post_acc", 1'b0, 32'hFFFF_0008, 4'hF, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
